// File: rtl/pwm_ramp_gen.sv
// Purpose : slew-limited PWM generator; duty follows the clamped setpoint one STEP per period.
// Latency : setpoint sampled on the boundary edge, applied to pwm_out in the following period;
//           enable low forces pwm_out low one cycle later. No backpressure (free-running).
//
// Ports:
//   clk          - system clock
//   reset_n      - asynchronous active-low reset
//   duty_sp      - requested duty (clocks high per period), clamped to PERIOD
//   enable       - actuator drive enable; low clears duty and forces output off at once
//   pwm_out      - registered PWM drive
//   duty_act     - duty currently applied
//   period_start - high during the cycle the period counter is 0
//   at_setpoint  - high while the applied duty has settled on the clamped setpoint
//
// Build option: define PWM_SOFTSTART_EN for the slew-limited ramp; without it the
// applied duty jumps straight to the target on each period boundary.
module pwm_ramp_gen #(
  parameter int PERIOD = 100000,
  parameter int WIDTH  = 17,
  parameter int STEP   = 2000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] duty_sp,
  input  logic             enable,
  output logic             pwm_out,
  output logic [WIDTH-1:0] duty_act,
  output logic             period_start,
  output logic             at_setpoint
);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_RAMP,
    ST_HOLD
  } state_t;

  localparam logic [WIDTH-1:0] C_PERIOD = WIDTH'(PERIOD);
  localparam logic [WIDTH-1:0] C_LAST   = WIDTH'(PERIOD - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_duty;
  logic [WIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_duty_next;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_duty_ramp;
  logic             w_boundary;

  assign w_boundary = (r_cnt == C_LAST);
  assign w_cnt_next = w_boundary ? '0 : r_cnt + WIDTH'(1);
  assign w_target   = (duty_sp > C_PERIOD) ? C_PERIOD : duty_sp;

`ifdef PWM_SOFTSTART_EN
  localparam logic [WIDTH:0] C_STEP = (WIDTH + 1)'(STEP);

  // One extra bit so differences and act+STEP can never wrap.
  logic [WIDTH:0] w_act_x;
  logic [WIDTH:0] w_tgt_x;

  assign w_act_x = {1'b0, r_duty};
  assign w_tgt_x = {1'b0, w_target};

  // Move at most STEP toward the target; snap onto it when within reach.
  always_comb begin
    w_duty_ramp = w_target;
    if (w_act_x < w_tgt_x) begin
      if ((w_tgt_x - w_act_x) > C_STEP) begin
        w_duty_ramp = WIDTH'(w_act_x + C_STEP);
      end
    end else if (w_act_x > w_tgt_x) begin
      if ((w_act_x - w_tgt_x) > C_STEP) begin
        w_duty_ramp = WIDTH'(w_act_x - C_STEP);
      end
    end
  end
`else
  // Without soft-start the target is taken in a single step; STEP only shapes the ramp.
  logic w_unused_step;
  assign w_unused_step = (STEP != 0);
  assign w_duty_ramp   = w_target;
`endif

  // Next state / next duty. Enable low wins over everything and does not wait
  // for the boundary; otherwise duty only moves on the boundary edge so each
  // period is produced with a single, stable duty value.
  always_comb begin
    w_state_next = r_state;
    w_duty_next  = r_duty;
    if (!enable) begin
      w_state_next = ST_OFF;
      w_duty_next  = '0;
    end else if (w_boundary) begin
      w_duty_next = w_duty_ramp;
      case (r_state)
        ST_OFF:  w_state_next = ST_RAMP;
        default: w_state_next = (w_duty_ramp == w_target) ? ST_HOLD : ST_RAMP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_OFF;
      r_cnt        <= '0;
      r_duty       <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      at_setpoint  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_duty       <= w_duty_next;
      // Looking at next count/duty makes the high phase start exactly at cnt 0
      // and keeps a full-scale duty high across the wrap.
      pwm_out      <= (w_state_next != ST_OFF) && (w_cnt_next < w_duty_next);
      period_start <= (w_cnt_next == '0);
      at_setpoint  <= (w_state_next == ST_HOLD);
    end
  end

  assign duty_act = r_duty;

endmodule

// File: tb/tb_pwm_ramp_gen.sv
// Purpose : self-checking bench for pwm_ramp_gen with a shortened period.
// Latency : expected outputs are queued one per cycle by the stimulus and
//           popped on the falling edge by an independent monitor.
module tb_pwm_ramp_gen;

  localparam int P = 200;
  localparam int W = 9;
  localparam int S = 40;

  logic         clk;
  logic         reset_n;
  logic         enable;
  logic [W-1:0] duty_sp;
  logic         pwm_out;
  logic [W-1:0] duty_act;
  logic         period_start;
  logic         at_setpoint;

  typedef struct packed {
    logic         pwm;
    logic [W-1:0] duty;
    logic         ps;
    logic         atsp;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: phase within the period, applied duty, drive on/off, settled flag.
  int m_cnt;
  int m_duty;
  bit m_on;
  bit m_at;
  bit m_ps;

  pwm_ramp_gen #(
    .PERIOD(P),
    .WIDTH (W),
    .STEP  (S)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .duty_sp     (duty_sp),
    .enable      (enable),
    .pwm_out     (pwm_out),
    .duty_act    (duty_act),
    .period_start(period_start),
    .at_setpoint (at_setpoint)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int ramp(input int d, input int t);
`ifdef PWM_SOFTSTART_EN
    if (d < t) return (t - d <= S) ? t : d + S;
    if (d > t) return (d - t <= S) ? t : d - S;
    return t;
`else
    return t + 0 * d;
`endif
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_duty = 0;
    m_on   = 0;
    m_at   = 0;
    m_ps   = 0;
  endtask

  task automatic model_edge(input bit en, input int sp);
    bit wrap;
    int tgt;
    wrap  = (m_cnt == P - 1);
    m_cnt = (m_cnt + 1) % P;
    tgt   = (sp > P) ? P : sp;
    if (!en) begin
      m_on   = 0;
      m_duty = 0;
      m_at   = 0;
    end else if (wrap) begin
      if (!m_on) begin
        m_on   = 1;
        m_duty = ramp(0, tgt);
        m_at   = 0;
      end else begin
        m_duty = ramp(m_duty, tgt);
        m_at   = (m_duty == tgt);
      end
    end
    m_ps = (m_cnt == 0);
  endtask

  // Each cycle: let the edge happen with the old inputs, advance the model,
  // apply new inputs just after the edge, then queue what the DUT must show.
  task automatic drive(input bit rst, input bit en, input int sp, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (reset_n) model_edge(enable, int'(duty_sp));
      else model_reset();
      #1;
      reset_n = rst;
      enable  = en;
      duty_sp = W'(sp);
      if (!rst) model_reset();
      q.push_back('{pwm: (m_on && (m_cnt < m_duty)), duty: W'(m_duty), ps: m_ps, atsp: m_at});
    end
  endtask

  // Run with the given inputs until the period counter reaches c (bounded by one period).
  task automatic to_cnt(input bit en, input int sp, input int c);
    for (int k = 0; k < P && m_cnt != c; k++) drive(1'b1, en, sp, 1);
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, req);
    end
  endtask

  // Monitor: one expected record per cycle, compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pwm_out", W'(pwm_out), W'(e.pwm));
        chk("duty_act", duty_act, e.duty);
        chk("period_start", W'(period_start), W'(e.ps));
        chk("at_setpoint", W'(at_setpoint), W'(e.atsp));
      end
    end
  end

  initial begin
    int r;
    int sp;
    reset_n = 1'b0;
    enable  = 1'b0;
    duty_sp = '0;
    model_reset();

    // Reset, release, stay disabled for one and a half periods.
    drive(1'b0, 1'b0, 0, 3);
    drive(1'b1, 1'b0, 100, P + P / 2);

    // Soft-start from OFF toward a non-multiple of the step.
    drive(1'b1, 1'b1, 100, 5 * P);

    // Setpoint change mid-period must not disturb the current period.
    to_cnt(1'b1, 100, 50);
    drive(1'b1, 1'b1, 170, P + 20);

    // Over-range setpoint clamps to full scale; output high across wraps.
    drive(1'b1, 1'b1, 511, 4 * P);

    // Ramp down to a value that is not on the step grid.
    drive(1'b1, 1'b1, 70, 6 * P);

    // Drop enable mid-period, then re-enable.
    drive(1'b1, 1'b1, 150, 3 * P);
    to_cnt(1'b1, 150, 60);
    drive(1'b1, 1'b0, 150, 5);
    drive(1'b1, 1'b1, 150, 3 * P);

    // Asynchronous reset mid-period with a large duty applied.
    to_cnt(1'b1, 150, 90);
    drive(1'b0, 1'b1, 150, 7);
    drive(1'b1, 1'b0, 150, P + 20);
    drive(1'b1, 1'b1, 150, 3 * P);

    // Random mix of setpoints, enable drops and resets.
    for (int it = 0; it < 40; it++) begin
      r  = int'($urandom_range(0, 9));
      sp = int'($urandom_range(0, 511));
      case (r)
        0:       drive(1'b1, 1'b0, sp, int'($urandom_range(1, 6)));
        1:       drive(1'b0, 1'b1, sp, int'($urandom_range(1, 3)));
        default: drive(1'b1, 1'b1, sp, int'($urandom_range(1, 2 * P)));
      endcase
    end

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected records left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_gen.md
# pwm_ramp_gen

Consumer of the 17-bit duty setpoint produced by the operator inc/dec counter. Generates the 1 kHz actuator PWM from the 100 MHz board clock. The applied duty is slew-limited toward the setpoint, one step per PWM period, so button presses never jerk the linear actuator. Duty changes take effect only on period boundaries, which keeps every PWM period glitch-free.

## Interface
Parameters:
- `PERIOD`, 100000: clocks per PWM period (1 kHz at 100 MHz).
- `WIDTH`, 17: width of the duty and counter buses; must hold `PERIOD`.
- `STEP`, 2000: maximum change of the applied duty per period (2 % of `PERIOD`).

Ports:
- `clk`, input, 1: system clock, 100 MHz.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `duty_sp`, input, WIDTH: requested duty in clocks-high per period, from the setpoint counter.
- `enable`, input, 1: actuator drive enable; low forces the output off.
- `pwm_out`, output, 1: registered PWM drive.
- `duty_act`, output, WIDTH: duty currently applied.
- `period_start`, output, 1: high during the cycle the period counter is 0.
- `at_setpoint`, output, 1: high when `duty_act` equals the clamped setpoint.

## Operation
- **Period counter `cnt`:** runs 0 to `PERIOD`-1 and wraps to 0. It runs in every state. The "boundary edge" is the clock edge at which `cnt` equals `PERIOD`-1.
- **Target:** `target = min(duty_sp, PERIOD)`. `duty_sp` is sampled only on the boundary edge; changes mid-period are ignored.
- **States:** OFF, RAMP, HOLD.
  - OFF: `duty_act` is held at 0. If `enable` is high on the boundary edge, go to RAMP. The new duty is computed on that same edge.
  - RAMP and HOLD: on every boundary edge the ramp rule is applied. Next state is HOLD if new `duty_act` equals `target`, otherwise RAMP.
  - Any state: if `enable` is low on any edge, go to OFF and clear `duty_act` to 0 on that edge. This is immediate and does not wait for the boundary.
- **Ramp rule:**
  - If `duty_act < target`: `duty_act = (target - duty_act <= STEP) ? target : duty_act + STEP`.
  - If `duty_act > target`: `duty_act = (duty_act - target <= STEP) ? target : duty_act - STEP`.
  - Compute differences in WIDTH+1 bits; no overflow or underflow is permitted.
- **`pwm_out`:** registered. It is high for exactly `duty_act` cycles per period, starting in the cycle where `cnt` is 0. The registered value is `(state != OFF) && (cnt_next < duty_next)`.
  - `duty_act` = 0 gives constantly low.
  - `duty_act` = `PERIOD` gives constantly high, with no low pulse at the wrap.
- **`at_setpoint`:** registered. It is `(state == HOLD)`.
- **`period_start`:** registered. It is `(cnt_next == 0)`.

## Timing
- **Reset values:** `cnt` = 0, `duty_act` = 0, state OFF, `pwm_out` = 0, `at_setpoint` = 0, `period_start` = 0.
- **First period after reset release:** `period_start` first rises when `cnt` wraps, i.e. in cycle `PERIOD` after reset release (the first cycle is cycle 0).
- **Setpoint-to-output latency:** a `duty_sp` change reaches `duty_act` at the next boundary edge. It is visible on `pwm_out` in the following period.
- **Ramp duration:** a full-scale ramp (0 to 100000) takes 50 periods.
- **Enable deassertion:** `pwm_out` goes low on the first edge where `enable` is seen low; there is one cycle of latency. The counter phase is preserved.
- **Reset mid-period:** all outputs go to their reset values asynchronously. Operation restarts with `cnt` = 0.

## Configuration
- **`PWM_SOFTSTART_EN` defined:** slew-limited ramp as described above.
- **`PWM_SOFTSTART_EN` undefined:** on each boundary edge in RAMP or HOLD, `duty_act` loads `target` directly. The OFF-to-RAMP transition also loads `target` in one step. `at_setpoint` is high one boundary after enable. `STEP` is unused.

## Test plan
- **Reset:** assert `reset_n` low mid-period with `duty_act` = 40000 -> all outputs 0 immediately; after release, `cnt` restarts at 0 and `pwm_out` stays low until enable.
- **Soft-start:** `enable` = 1, `duty_sp` = 10000 from OFF -> successive periods have `pwm_out` high for 2000, 4000, 6000, 8000 and 10000 cycles; `at_setpoint` rises with the 10000 period.
- **Clamp and full scale:** `duty_sp` = 131071 with `duty_act` at 98000 -> next period `duty_act` = 100000 and `pwm_out` continuously high across the wrap; `at_setpoint` = 1.
- **Ramp down, non-multiple:** `duty_act` = 10000, `duty_sp` = 7000 -> 8000, then 7000; no undershoot below 7000.
- **Mid-period behaviour:** change `duty_sp` at `cnt` = 500 -> current period unchanged. Then drop `enable` at `cnt` = 300 with `duty_act` = 6000 -> `pwm_out` low the next cycle, `duty_act` = 0, state OFF.
- **`PWM_SOFTSTART_EN` undefined:** `duty_sp` = 50000 from OFF -> first enabled period high for 50000 cycles.
